// File: rtl/score_digits_draw.sv
`default_nettype none
// ---- score_digits_draw : 4-digit BCD score keeper + seven-segment renderer -- rev 1.0 ----
module score_digits_draw #(
  parameter int         TOP_LEFT_X  = 16,
  parameter int         TOP_LEFT_Y  = 8,
  parameter logic [7:0] DIGIT_COLOR = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        addPointsValid,
  input  logic [7:0]  addPoints,
  input  logic        clearScore,
  output logic        busy,
  output logic [15:0] scoreBCD,
  output logic        pointsDrawingRequest,
  output logic [7:0]  pointsRGB
);

  localparam logic [10:0] c_x0 = TOP_LEFT_X[10:0];
  localparam logic [10:0] c_y0 = TOP_LEFT_Y[10:0];

  typedef enum logic [0:0] {IDLE = 1'b0, ADDING = 1'b1} state_t;

  state_t      state_q;
  logic [7:0]  remaining_q;
  logic [15:0] score_q;
  logic [15:0] shadow_q;
  logic        req_q;
  logic [7:0]  rgb_q;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Render path: range check first, so coordinates below the origin cannot wrap in
  logic [10:0] dx_w, dy_w;
  logic        in_area_w;
  logic [2:0]  col_w;
  logic [3:0]  row_w;
  logic [3:0]  nibble_w;
  logic [6:0]  segmap_w;
  logic [6:0]  hit_w;
  logic        lit_d;

  assign dx_w      = pixelX - c_x0;
  assign dy_w      = pixelY - c_y0;
  assign in_area_w = (pixelX >= c_x0) && (dx_w < 11'd64) &&
                     (pixelY >= c_y0) && (dy_w < 11'd32);
  assign col_w     = dx_w[3:1];
  assign row_w     = dy_w[4:1];

  always_comb begin
    nibble_w = 4'd0;
    case (dx_w[5:4])
      2'd0:    nibble_w = shadow_q[15:12];
      2'd1:    nibble_w = shadow_q[11:8];
      2'd2:    nibble_w = shadow_q[7:4];
      default: nibble_w = shadow_q[3:0];
    endcase
  end

  // segmap bit order: {a,b,c,d,e,f,g}
  always_comb begin
    segmap_w = 7'b0000000;
    case (nibble_w)
      4'd0: segmap_w = 7'b1111110;
      4'd1: segmap_w = 7'b0110000;
      4'd2: segmap_w = 7'b1101101;
      4'd3: segmap_w = 7'b1111001;
      4'd4: segmap_w = 7'b0110011;
      4'd5: segmap_w = 7'b1011011;
      4'd6: segmap_w = 7'b1011111;
      4'd7: segmap_w = 7'b1110000;
      4'd8: segmap_w = 7'b1111111;
      4'd9: segmap_w = 7'b1111011;
      default: segmap_w = 7'b0000000;
    endcase
  end

  always_comb begin
    hit_w    = 7'b0000000;
    hit_w[6] = (row_w >= 4'd1)  && (row_w <= 4'd2)  && (col_w >= 3'd1) && (col_w <= 3'd6);
    hit_w[5] = (row_w >= 4'd1)  && (row_w <= 4'd8)  && (col_w >= 3'd6);
    hit_w[4] = (row_w >= 4'd7)  && (row_w <= 4'd14) && (col_w >= 3'd6);
    hit_w[3] = (row_w >= 4'd13) && (row_w <= 4'd14) && (col_w >= 3'd1) && (col_w <= 3'd6);
    hit_w[2] = (row_w >= 4'd7)  && (row_w <= 4'd14) && (col_w <= 3'd1);
    hit_w[1] = (row_w >= 4'd1)  && (row_w <= 4'd8)  && (col_w <= 3'd1);
    hit_w[0] = (row_w >= 4'd7)  && (row_w <= 4'd8)  && (col_w >= 3'd1) && (col_w <= 3'd6);
    lit_d    = in_area_w && ((segmap_w & hit_w) != 7'b0000000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= 8'd0;
      score_q     <= 16'h0000;
      shadow_q    <= 16'h0000;
      req_q       <= 1'b0;
      rgb_q       <= 8'h00;
    end else begin
      req_q <= lit_d;
      rgb_q <= lit_d ? DIGIT_COLOR : 8'h00;
      if (startOfFrame) shadow_q <= score_q;
      if (clearScore) begin
        state_q     <= IDLE;
        remaining_q <= 8'd0;
        score_q     <= 16'h0000;
      end else begin
        case (state_q)
          IDLE: begin
            if (addPointsValid && (addPoints != 8'd0)) begin
              remaining_q <= addPoints;
              state_q     <= ADDING;
            end
          end
          ADDING: begin
            // At 9999 the score saturates while the award keeps draining
            if (score_q != 16'h9999) score_q <= bcd_inc(score_q);
            remaining_q <= remaining_q - 8'd1;
            if (remaining_q == 8'd1) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy                 = (state_q == ADDING);
  assign scoreBCD             = score_q;
  assign pointsDrawingRequest = req_q;
  assign pointsRGB            = rgb_q;

endmodule
`default_nettype wire

// File: doc/score_digits_draw.md
# score_digits_draw

Score keeper and renderer feeding the points input pair of the objects mux. It accepts point awards from the game logic and accumulates them into a 4-digit BCD score, one point per clock, with a busy handshake. Each frame it renders the score as seven-segment style digits at a fixed screen position. Its outputs, `pointsDrawingRequest` and `pointsRGB`, are registered and go straight into the mux one cycle after the pixel coordinates they describe.

## Interface
Parameters:
- `TOP_LEFT_X`, 16: x of the left edge of the leftmost digit.
- `TOP_LEFT_Y`, 8: y of the top edge of all digits.
- `DIGIT_COLOR`, 8'hFF: RGB332 value of lit digit pixels.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `pixelX`  in  11  current VGA pixel column.
- `pixelY`  in  11  current VGA pixel row.
- `startOfFrame`  in  1  one-cycle pulse at the start of each frame.
- `addPointsValid`  in  1  award request.
- `addPoints`  in  8  award amount, binary 0..255.
- `clearScore`  in  1  zeroes the score (new game).
- `busy`  out  1  high while an award is being accumulated.
- `scoreBCD`  out  16  live score, 4 BCD digits, MSD in [15:12].
- `pointsDrawingRequest`  out  1  registered: pixel is a lit digit pixel.
- `pointsRGB`  out  8  registered pixel colour.

## Operation
- Accumulator FSM, states IDLE and ADDING:
  - IDLE: when `addPointsValid` is high and `addPoints` is nonzero, latch `remaining = addPoints` and go to ADDING.
  - IDLE: when `addPointsValid` is high and `addPoints` is 0, the request is accepted and has no effect.
  - ADDING: each cycle, add 1 to the score in BCD and decrement `remaining`. When `remaining` reaches 0, return to IDLE.
  - `busy` is high exactly while in ADDING.
  - `addPointsValid` while busy is ignored and dropped; the requester must wait for `busy` to be low.
- BCD increment: a digit equal to 9 wraps to 0 and carries into the next digit.
- Saturation: at 9999 the score holds, and `remaining` keeps draining at one per cycle.
- `clearScore` has priority over everything else:
  - the score goes to 0 and the FSM goes to IDLE with `remaining` at 0;
  - an award presented in the same cycle is dropped.
- Display shadow: on the `startOfFrame` cycle the shadow register loads the current `scoreBCD`, i.e. the value before that cycle's update. Rendering uses only the shadow, so there is no tearing mid-frame.
- Digit area:
  - 4 digits, each 16x32 pixels, adjacent, MSD leftmost.
  - Digit k (k=0 is the MSD) covers x in [TOP_LEFT_X+16k, TOP_LEFT_X+16k+16) and y in [TOP_LEFT_Y, TOP_LEFT_Y+32).
  - Leading zeros are drawn.
- Glyph grid: 8x16 cells, each cell 2x2 pixels.
  - col = ((pixelX-TOP_LEFT_X) mod 16) >> 1
  - row = (pixelY-TOP_LEFT_Y) >> 1
- Segments, as (rows; cols):
  - a (1-2; 1-6)
  - b (1-8; 6-7)
  - c (7-14; 6-7)
  - d (13-14; 1-6)
  - e (7-14; 0-1)
  - f (1-8; 0-1)
  - g (7-8; 1-6)
- Digit segment maps:
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg
  - 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg
- Pixel outputs:
  - A pixel is lit when it lies inside the digit area and inside any active segment of its digit. Then `pointsDrawingRequest`=1 and `pointsRGB`=DIGIT_COLOR.
  - Otherwise `pointsDrawingRequest`=0 and `pointsRGB`=8'h00.
  - All coordinate arithmetic is unsigned and 11 bits wide. Coordinates left of or above the area fail the range check and must not wrap into it.

## Timing
- Reset, synchronous:
  - score, shadow, `remaining` = 0; FSM in IDLE;
  - `busy`=0, `scoreBCD`=16'h0000, `pointsDrawingRequest`=0, `pointsRGB`=8'h00.
- Award handshake:
  - accepted in cycle T;
  - `busy` is high in cycles T+1..T+n;
  - `scoreBCD` has risen by 1 at the end of each of those cycles, reaching +n visible in T+n+1;
  - `busy`=0 in T+n+1, and a new award may be presented that cycle.
- An award of 0 never raises `busy`.
- Render latency: exactly 1 clock from `pixelX`/`pixelY` to `pointsDrawingRequest`/`pointsRGB`.
- `scoreBCD` is a register output: it reflects the state after the last clock edge.
- Reset or `clearScore` mid-ADDING aborts the award; no further increments occur.
- A `startOfFrame` pulse coinciding with an increment captures the pre-increment value.

## Test plan
- Reset, then award 5 at T: `busy` is high T+1..T+5, `scoreBCD` reads 16'h0005 at T+6, `busy`=0.
- Score 16'h0098, award 3: the sequence is 0099, 0100, 0101, showing BCD carry across two digits.
- Score 16'h9998, award 10: `busy` is high 10 cycles and `scoreBCD` ends at 16'h9999. Then award 0: `busy` stays 0.
- Award 200 and assert `clearScore` 20 cycles later: `scoreBCD`=0 and `busy`=0 on the next cycle, with no further change. Also assert `clearScore` together with `addPointsValid`: `busy` stays 0.
- Score 1234 with `startOfFrame` pulsed, defaults:
  - pixel (16+2, 8+2), in digit '1', segment a off: request=0;
  - pixel (16+13, 8+4), segment b: request=1, RGB=8'hFF;
  - pixel (48+4, 8+15), digit '3', g: request=1;
  - pixel (15, 10): request=0.
  - Each result appears one cycle after the pixel is applied.
- Display shadow: after an award completes mid-frame, `scoreBCD` shows the new value but the rendered digits keep the old value until the next `startOfFrame`.
